// File: rtl/spi_tx_queue.sv
// spi_tx_queue
//   CPU-side transmit queue in front of the 10-bit SPI output driver. Memory-mapped writes
//   are buffered in a FIFO and handed to the driver one at a time. The driver exposes no
//   busy flag, so consecutive start pulses are paced by a fixed hold-off chosen from the
//   word type: a power-on word (bit 9 set) needs only PWR_CYCLES, a data/command word
//   needs XFER_CYCLES (long enough for the driver to shift the whole frame).
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   wr_en       in   push request (cs3 && memwrite)
//   wr_data     in   [9:0] {pwr, d/c, byte}
//   status_clr  in   clears the sticky overflow flag
//   status      out  [31:0] {20'h0, ovf, busy, full, empty, 3'h0, count[4:0]}
//   spi_start   out  one-cycle start pulse to the SPI driver
//   spi_din     out  [9:0] word for the driver, held until the next issue
//   irq         out  drain-complete pulse
//
// Build option
//   SPI_TX_QUEUE_IRQ_EN  when defined, irq pulses once when the issuer returns to idle and
//                        the queue has fully drained; otherwise irq is tied low.

module spi_tx_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned XFER_CYCLES = 460,
    parameter int unsigned PWR_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [9:0]  wr_data,
    input  logic        status_clr,
    output logic [31:0] status,
    output logic        spi_start,
    output logic [9:0]  spi_din,
    output logic        irq
);

    // Hold-off counter is sized for the longer of the two gaps.
    localparam int unsigned MaxHold = (XFER_CYCLES > PWR_CYCLES) ? XFER_CYCLES : PWR_CYCLES;
    localparam int unsigned GW      = (MaxHold > 2) ? $clog2(MaxHold) : 1;
    localparam int unsigned CW      = AW + 1;

    localparam logic [GW-1:0] XferLoad = GW'(XFER_CYCLES - 1);
    localparam logic [GW-1:0] PwrLoad  = GW'(PWR_CYCLES - 1);
    localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);

    typedef enum logic {
        StIdle,
        StGap
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            start_q, start_d;
    logic [9:0]      din_q, din_d;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [9:0]      mem_q [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            overflow;
    logic            busy;
    logic            gap_done;
    logic [9:0]      head;

    // ------------------------------------------------------------------
    // FIFO flags and handshake (all flags are start-of-cycle values)
    // ------------------------------------------------------------------
    assign full     = (count_q == FullCnt);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];

    // A write while full is dropped even if the issuer pops in the same cycle.
    assign push     = wr_en && !full;
    assign overflow = wr_en && full;

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed; pointers define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow flag
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new overflow wins over a simultaneous clear.
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (status_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Issuer FSM
    //   Start at cycle S, GAP occupies S .. S+H-1, IDLE at S+H, so back-to-back starts
    //   land H+1 cycles apart.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        start_d  = 1'b0;
        din_d    = din_q;
        pop      = 1'b0;
        gap_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    din_d   = head;
                    gap_d   = head[9] ? PwrLoad : XferLoad;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    gap_done = 1'b1;
                    state_d  = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gap_q   <= '0;
            start_q <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            start_q <= start_d;
            din_q   <= din_d;
        end
    end

    // ------------------------------------------------------------------
    // Drain-complete interrupt
    // ------------------------------------------------------------------
`ifdef SPI_TX_QUEUE_IRQ_EN
    // drain_chk_q marks the first IDLE cycle after a gap; irq follows one cycle later if
    // nothing is queued and no push lands in that IDLE cycle. An empty FIFO cannot be
    // full, so wr_en alone means a push arrives.
    logic drain_chk_q;
    logic irq_q, irq_d;

    always_comb begin
        irq_d = drain_chk_q && empty && !wr_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_chk_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            drain_chk_q <= gap_done;
            irq_q       <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_gap_done;
    assign unused_gap_done = gap_done;
    assign irq             = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state_q != StIdle) || !empty;
    assign spi_start = start_q;
    assign spi_din   = din_q;
    assign status    = {20'h0, ovf_q, busy, full, empty, 3'h0, 5'(count_q)};

`ifndef SYNTHESIS
    // The driver must never see a start pulse wider than one cycle.
    a_start_single: assert property (@(posedge clk) disable iff (reset)
        spi_start |=> !spi_start);
`endif

endmodule

// File: tb/tb_spi_tx_queue.sv
// Scoreboard bench for spi_tx_queue. A time-based reference model (a word queue plus the
// cycle at which the issuer next becomes free) predicts every start pulse, the held word,
// the status word and the irq line; a negedge monitor compares the DUT against it.
module tb_spi_tx_queue;

    localparam int DEPTH = 16;
    localparam int XFER  = 460;
    localparam int PWR   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [9:0]  wr_data;
    logic        status_clr;
    logic [31:0] status;
    logic        spi_start;
    logic [9:0]  spi_din;
    logic        irq;

    spi_tx_queue dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .status_clr (status_clr),
        .status     (status),
        .spi_start  (spi_start),
        .spi_din    (spi_din),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int         at;
        logic [9:0] w;
    } ev_t;

    logic [9:0]  mq[$];       // words waiting in the queue
    ev_t         sb[$];       // expected start pulses
    int          cyc = 0;     // index of the current cycle
    int          next_idle = 0;
    bit          had_start = 0;
    bit          m_ovf = 0;
    logic [9:0]  m_din = '0;
    logic [31:0] exp_status = 32'h100;
    bit          exp_irq = 0;

    bit          was_full, was_empty, issue, irq_n, busy_n;
    logic [9:0]  mw;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            sb.delete();
            m_ovf     = 0;
            m_din     = '0;
            next_idle = 0;
            had_start = 0;
            exp_irq   = 0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            issue     = !was_empty && (cyc >= next_idle);
`ifdef SPI_TX_QUEUE_IRQ_EN
            irq_n = had_start && (cyc == next_idle) && was_empty && !wr_en;
`else
            irq_n = 0;
`endif
            if (issue) begin
                mw = mq.pop_front();
                sb.push_back('{at: cyc + 1, w: mw});
                m_din     = mw;
                next_idle = cyc + 1 + (mw[9] ? PWR : XFER);
                had_start = 1;
            end
            if (wr_en && !was_full) mq.push_back(wr_data);
            if (wr_en && was_full) m_ovf = 1;
            else if (status_clr) m_ovf = 0;
            exp_irq = irq_n;
        end
        cyc++;
        busy_n     = (cyc < next_idle) || (mq.size() != 0);
        exp_status = {20'h0, m_ovf, busy_n, mq.size() == DEPTH, mq.size() == 0, 3'h0,
                      5'(mq.size())};
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int n_starts = 0;
    int last_start = -1;
    int n_irq = 0;
    int last_irq = -1;

    always @(negedge clk) begin
        if (!reset) begin
            if (spi_start) begin
                n_starts++;
                last_start = cyc;
            end
            if (irq) begin
                n_irq++;
                last_irq = cyc;
            end
            if (sb.size() > 0 && sb[0].at == cyc) begin
                check("start_pulse", {31'h0, spi_start}, 32'h1);
                check("start_word", {22'h0, spi_din}, {22'h0, sb[0].w});
                void'(sb.pop_front());
            end else begin
                check("no_start", {31'h0, spi_start}, 32'h0);
            end
            check("din_hold", {22'h0, spi_din}, {22'h0, m_din});
            check("status", status, exp_status);
            check("irq", {31'h0, irq}, {31'h0, exp_irq});
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic step(input logic we, input logic [9:0] d, input logic clr);
        @(negedge clk);
        wr_en      = we;
        wr_data    = d;
        status_clr = clr;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((mq.size() != 0 || cyc < next_idle + 2) && k < 20000) begin
            step(1'b0, 10'h0, 1'b0);
            k++;
        end
        check("drain_bound", {31'h0, k < 20000}, 32'h1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n0, i0, t;

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_data    = '0;
        status_clr = 1'b0;

        // 1: reset values
        #1;
        check("rst_status", status, 32'h100);
        check("rst_start", {31'h0, spi_start}, 32'h0);
        check("rst_din", {22'h0, spi_din}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) step(1'b0, 10'h0, 1'b0);

        // 2 and 6: single data word
        n0 = n_starts;
        i0 = n_irq;
        step(1'b1, 10'h155, 1'b0);
        t = cyc;
        step(1'b0, 10'h0, 1'b0);
        repeat (480) step(1'b0, 10'h0, 1'b0);
        check("t2_start_cycle", last_start, t + 2);
        check("t2_start_count", n_starts - n0, 1);
        check("t2_din", {22'h0, spi_din}, 32'h155);
        check("t2_status_end", status, 32'h100);
`ifdef SPI_TX_QUEUE_IRQ_EN
        check("t6_irq_count", n_irq - i0, 1);
        check("t6_irq_cycle", last_irq, t + 2 + 461);
`endif
        wait_drain();

        // 3: power word then data word
        n0 = n_starts;
        step(1'b1, 10'h200, 1'b0);
        t = cyc;
        step(1'b1, 10'h0AF, 1'b0);
        step(1'b0, 10'h0, 1'b0);
        repeat (4) step(1'b0, 10'h0, 1'b0);
        check("t3_start_count", n_starts - n0, 2);
        check("t3_second_start", last_start, t + 2 + PWR + 1);
        check("t3_din", {22'h0, spi_din}, 32'h0AF);
        wait_drain();

        // 4: overflow and sticky flag
        for (int i = 0; i < 18; i++) step(1'b1, 10'(i), 1'b0);
        step(1'b0, 10'h0, 1'b0);
        check("t4_full_ovf", status, 32'hE10);
        step(1'b0, 10'h0, 1'b1);
        step(1'b1, 10'h3F, 1'b1);
        check("t4_cleared", status, 32'h610);
        step(1'b0, 10'h0, 1'b0);
        check("t4_set_wins", status, 32'hE10);
        step(1'b0, 10'h0, 1'b1);
        step(1'b0, 10'h0, 1'b0);
        wait_drain();

        // 5: reset mid-gap with 5 words queued
        for (int i = 0; i < 6; i++) step(1'b1, 10'h40 + 10'(i), 1'b0);
        step(1'b0, 10'h0, 1'b0);
        repeat (50) step(1'b0, 10'h0, 1'b0);
        check("t5_pre_status", status, 32'h405);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_status", status, 32'h100);
        check("t5_rst_start", {31'h0, spi_start}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n0 = n_starts;
        repeat (600) step(1'b0, 10'h0, 1'b0);
        check("t5_no_start", n_starts - n0, 0);
        check("t5_idle_status", status, 32'h100);

        // Randomized traffic, mostly power words to keep throughput up
        for (int i = 0; i < 5000; i++) begin
            step($urandom_range(0, 99) < 15,
                 {$urandom_range(0, 9) != 0, 9'($urandom_range(0, 511))},
                 $urandom_range(0, 19) == 0);
        end
        step(1'b0, 10'h0, 1'b0);
        wait_drain();

        check("sb_empty", sb.size(), 0);
`ifndef SPI_TX_QUEUE_IRQ_EN
        check("irq_never", n_irq, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
